// File: rtl/oled_pkg.sv
// oled_pkg: shared types and constants for the OLED command scheduler.
// Holds the dispatcher state encoding, the OLED mode codes and the default
// mode/colour widths used by the scheduler top.
package oled_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } disp_state_t;

  localparam logic [1:0] MODE_TURNON = 2'b00;
  localparam logic [1:0] MODE_COLOR  = 2'b01;

  localparam int DEF_N_MODE_BITS  = 2;
  localparam int DEF_N_COLOR_BITS = 8;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel. Two-flop synchroniser, then a counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive cycles of
// it. `rise` is a one-cycle pulse coincident with the accepted 0->1 change.
// With OLED_AUTO_REPEAT_EN defined, `rise` also pulses every AUTO_PERIOD
// cycles while the debounced level stays high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef OLED_AUTO_REPEAT_EN
  , parameter int AUTO_PERIOD = 10000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;
  logic          settle;
  logic          up;

  // settle: this cycle is the last of the required stable run
  assign settle = (sync_b != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign up     = settle && sync_b;

  // two-flop synchroniser for the raw asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // stable-run counter; any sample equal to the current level restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (settle) begin
      level <= sync_b;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef OLED_AUTO_REPEAT_EN
  localparam int RW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_hit;

  assign rep_hit = level && (rep_cnt == RW'(AUTO_PERIOD - 1));

  // repeat timer restarts on every accepted press and on every repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (up || !level || rep_hit) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign rise = up | rep_hit;
`else
  assign rise = up;
`endif

endmodule

// File: rtl/oled_cmd_scheduler.sv
// oled_cmd_scheduler: debounces N_BTN buttons, queues one request per
// accepted press (mode slice + colour snapshot) and dispatches them to the
// OLED interface over its START/READY handshake.
// Optional feature macro: OLED_AUTO_REPEAT_EN (auto-repeat while held).
module oled_cmd_scheduler
  import oled_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int N_MODE_BITS     = DEF_N_MODE_BITS,
  parameter int N_COLOR_BITS    = DEF_N_COLOR_BITS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4,
  parameter int ACK_TIMEOUT     = 16,
  parameter int AUTO_PERIOD     = 10000000
) (
  input  logic                           i_CLK,
  input  logic                           i_RST_N,
  input  logic [N_BTN-1:0]               i_BTN,
  input  logic [N_BTN*N_MODE_BITS-1:0]   i_BTN_MODE,
  input  logic [N_COLOR_BITS-1:0]        i_COLOR,
  input  logic                           i_READY,
  output logic                           o_START,
  output logic [N_MODE_BITS-1:0]         o_MODE,
  output logic [N_COLOR_BITS-1:0]        o_BACKGROUND_COLOR,
  output logic                           o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]    o_FIFO_COUNT,
  output logic                           o_OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = N_MODE_BITS + N_COLOR_BITS;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (ACK_TIMEOUT < 1 || AUTO_PERIOD < 1) begin : g_period_chk
    $error("ACK_TIMEOUT and AUTO_PERIOD must be positive");
  end

  logic [N_BTN-1:0]       rise;
  logic [N_BTN-1:0]       pending;
  logic [N_BTN-1:0]       first;
  logic [N_BTN-1:0]       clr;
  logic [N_MODE_BITS-1:0] sel_mode;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   push;
  logic                   pop;
  disp_state_t            state;
  disp_state_t            state_nxt;
  logic [TW-1:0]          timer;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef OLED_AUTO_REPEAT_EN
      , .AUTO_PERIOD(AUTO_PERIOD)
`endif
    ) u_debounce (
      .clk  (i_CLK),
      .rst_n(i_RST_N),
      .btn  (i_BTN[g]),
      .rise (rise[g])
    );
  end

  // lowest-index pending button wins (descending scan, last hit sticks)
  always_comb begin
    first    = '0;
    sel_mode = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        first    = '0;
        first[i] = 1'b1;
        sel_mode = i_BTN_MODE[i*N_MODE_BITS +: N_MODE_BITS];
      end
    end
  end

  // a pop in the same cycle frees the slot a full queue needs for the push
  assign full         = (count == CW'(FIFO_DEPTH));
  assign push         = (|pending) && (!full || pop);
  assign clr          = {N_BTN{push}} & first;
  assign o_FIFO_COUNT = count;
  assign o_BUSY       = (state != IDLE);

  // pending flags and sticky loss flag; a flag being consumed this cycle can absorb a new press
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      pending    <= '0;
      o_OVERFLOW <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (|(rise & pending & ~clr)) o_OVERFLOW <= 1'b1;
    end
  end

  // queue storage; contents are qualified by the pointers so need no reset
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr] <= {sel_mode, i_COLOR};
  end

  // queue pointers and occupancy
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // dispatcher state register
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // dispatcher next state; a missing acknowledge is treated as completion after ACK_TIMEOUT
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && i_READY) begin
          pop       = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!i_READY)                              state_nxt = WAIT_DONE;
        else if (timer == TW'(ACK_TIMEOUT - 1))    state_nxt = IDLE;
      end
      WAIT_DONE: begin
        if (i_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // acknowledge timer runs only while waiting for READY to fall
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N)               timer <= '0;
    else if (state != WAIT_ACK) timer <= '0;
    else                        timer <= timer + 1'b1;
  end

  // start pulse and request fields, held until the next pop
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_START            <= 1'b0;
      o_MODE             <= N_MODE_BITS'(MODE_TURNON);
      o_BACKGROUND_COLOR <= '0;
    end else begin
      o_START <= pop;
      if (pop) {o_MODE, o_BACKGROUND_COLOR} <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_oled_cmd_scheduler.sv
// tb_oled_cmd_scheduler: randomized and directed stimulus for
// oled_cmd_scheduler, checked every cycle against a behavioural model
// (sliding-window debounce, request queue, handshake phases).
// Honours OLED_AUTO_REPEAT_EN when defined for the build.
module tb_oled_cmd_scheduler;
  import oled_pkg::*;

  localparam int N_BTN = 4;
  localparam int N_MB  = 2;
  localparam int N_CB  = 8;
  localparam int DEB   = 8;
  localparam int DEPTH = 2;
  localparam int ACK   = 16;
  localparam int AUTO  = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_BTN-1:0]  btn = '0;
  logic [N_BTN*N_MB-1:0] btn_mode = '0;
  logic [N_CB-1:0]   color = '0;
  logic              ready = 1'b1;
  logic              o_start;
  logic [N_MB-1:0]   o_mode;
  logic [N_CB-1:0]   o_bg;
  logic              o_busy;
  logic [$clog2(DEPTH):0] o_cnt;
  logic              o_ovf;

  always #5 clk = ~clk;

  oled_cmd_scheduler #(
    .N_BTN(N_BTN), .N_MODE_BITS(N_MB), .N_COLOR_BITS(N_CB),
    .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(ACK),
    .AUTO_PERIOD(AUTO)
  ) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_BTN(btn), .i_BTN_MODE(btn_mode),
    .i_COLOR(color), .i_READY(ready), .o_START(o_start), .o_MODE(o_mode),
    .o_BACKGROUND_COLOR(o_bg), .o_BUSY(o_busy), .o_FIFO_COUNT(o_cnt),
    .o_OVERFLOW(o_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [N_MB-1:0] mode;
    logic [N_CB-1:0] color;
  } req_t;

  bit [DEB:0]       hist [N_BTN];   // hist[i][0] = most recent raw sample
  bit [N_BTN-1:0]   m_lvl;
  bit [N_BTN-1:0]   m_pend;
  req_t             q[$];
  bit               m_start;
  bit [N_MB-1:0]    m_mode;
  bit [N_CB-1:0]    m_color;
  bit               m_ovf;
  int               m_phase;        // 0 idle, 1 awaiting ack, 2 awaiting done
  int               m_wait;
  int unsigned      m_edge;
  int unsigned      m_last_rise [N_BTN];

  task automatic model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      hist[i] = '0;
      m_last_rise[i] = 0;
    end
    m_lvl = '0; m_pend = '0; q.delete();
    m_start = 0; m_mode = '0; m_color = '0; m_ovf = 0;
    m_phase = 0; m_wait = 0; m_edge = 0;
  endtask

  task automatic model_step();
    bit pop, push, full, lv, flip;
    int sel;
    bit [N_BTN-1:0] rs;
    req_t r;
    m_edge++;
    sel = -1;
    rs = '0;
    pop  = (m_phase == 0) && (q.size() > 0) && (ready == 1'b1);
    full = (q.size() == DEPTH);
    for (int i = 0; i < N_BTN; i++) if (m_pend[i] && sel < 0) sel = i;
    push = (sel >= 0) && (!full || pop);
    for (int i = 0; i < N_BTN; i++) begin
      lv = m_lvl[i];
      flip = 1'b1;
      for (int j = 1; j <= DEB; j++) if (hist[i][j] == lv) flip = 1'b0;
      if (flip) begin
        m_lvl[i] = !lv;
        if (!lv) begin rs[i] = 1'b1; m_last_rise[i] = m_edge; end
      end
`ifdef OLED_AUTO_REPEAT_EN
      if (lv && (m_edge - m_last_rise[i] == AUTO)) begin
        rs[i] = 1'b1;
        m_last_rise[i] = m_edge;
      end
`endif
      hist[i] = {hist[i][DEB-1:0], bit'(btn[i])};
    end
    for (int i = 0; i < N_BTN; i++)
      if (rs[i] && m_pend[i] && !(push && sel == i)) m_ovf = 1'b1;
    m_start = pop;
    if (pop) begin
      m_mode = q[0].mode;
      m_color = q[0].color;
      void'(q.pop_front());
    end
    if (push) begin
      r.mode = btn_mode[sel*N_MB +: N_MB];
      r.color = color;
      q.push_back(r);
      m_pend[sel] = 1'b0;
    end
    m_pend |= rs;
    case (m_phase)
      0: if (pop) begin m_phase = 1; m_wait = 0; end
      1: if (!ready) m_phase = 2;
         else begin m_wait++; if (m_wait == ACK) m_phase = 0; end
      default: if (ready) m_phase = 0;
    endcase
  endtask

  // ---------------- OLED responder and cycle driver ----------------
  bit   resp_en = 0;
  int   r_ack = -1;
  int   r_low = 0;
  int   n_start = 0;
  int   peak = 0;
  logic [N_MB-1:0] start_log[$];

  task automatic responder();
    if (o_start) r_ack = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 2));
    if (r_ack == 0) begin
      ready = 1'b0;
      r_low = $urandom_range(1, 30);
      r_ack = -1;
    end else if (r_ack > 0) begin
      r_ack--;
    end else if (r_low > 0) begin
      r_low--;
      if (r_low == 0) ready = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("start", o_start, m_start);
    check("mode", o_mode, m_mode);
    check("color", o_bg, m_color);
    check("busy", o_busy, m_phase != 0);
    check("count", o_cnt, q.size());
    check("overflow", o_ovf, m_ovf);
    if (o_start) begin n_start++; start_log.push_back(o_mode); end
    if (int'(o_cnt) > peak) peak = o_cnt;
    if (resp_en) responder();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int guard;
    logic [N_MB-1:0] m0;
    // reset with all buttons held
    btn = '1;
    #1 rst_n = 1'b0;
    model_reset();
    run(5);
    check("rst_count", o_cnt, 0);
    btn = '0;
    rst_n = 1'b1;
    run(20);
    check("no_start_after_rst", n_start, 0);

    // bounce: toggling faster than the debounce window, then a clean hold
    btn_mode = $urandom;
    btn_mode[1:0] = MODE_COLOR;
    m0 = btn_mode[1:0];
    n_start = 0;
    for (int k = 0; k < 8; k++) begin
      btn[0] = ~btn[0];
      color = $urandom;
      run(3);
    end
    btn[0] = 1'b1;
    run(12);
    btn[0] = 1'b0;
    run(40);
    check("bounce_starts", n_start, 1);
    check("bounce_mode", start_log[start_log.size()-1], m0);

    // simultaneous press of btn1/btn2 while the interface is not ready
    btn_mode = {2'b11, 2'b10, 2'b01, MODE_TURNON};
    ready = 1'b0;
    peak = 0;
    start_log.delete();
    btn = 4'b0110;
    run(14);
    btn = '0;
    run(4);
    check("simul_peak", peak, 2);
    ready = 1'b1;
    run(60);
    check("simul_n", start_log.size(), 2);
    if (start_log.size() >= 2) begin
      check("simul_first", start_log[0], 2'b01);
      check("simul_second", start_log[1], 2'b10);
    end

    // randomized traffic with a responsive interface
    resp_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        int b;
        b = $urandom_range(0, N_BTN - 1);
        btn[b] = ~btn[b];
      end
      color = $urandom;
      if ($urandom_range(0, 49) == 0) btn_mode = $urandom;
      cycle();
    end

    // reset while a request is in flight
    btn = 4'b0100;
    guard = 0;
    while (!o_busy && guard < 200) begin cycle(); guard++; end
    check("busy_before_rst", o_busy, 1);
    #2 rst_n = 1'b0;
    model_reset();
    resp_en = 0; r_ack = -1; r_low = 0;
    ready = 1'b1;
    #1;
    check("rst_async_start", o_start, 0);
    check("rst_async_busy", o_busy, 0);
    run(3);
    btn = '0;
    rst_n = 1'b1;
    n_start = 0;
    run(20);
    check("no_start_after_rst2", n_start, 0);
    check("ovf_clear", o_ovf, 0);

    // overflow: presses on btn3 with the interface held busy
    ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      btn[3] = 1'b1; color = $urandom; run(12);
      btn[3] = 1'b0; run(12);
    end
    check("ovf_full_count", o_cnt, DEPTH);
    check("ovf_set", o_ovf, 1);
    ready = 1'b1;
    guard = 0;
    while ((o_cnt != 0 || o_busy) && guard < 300) begin cycle(); guard++; end
    check("drain_within_bound", guard < 300, 1);
    check("ovf_sticky", o_ovf, 1);

    // long hold on btn0: repeats only when auto-repeat is built in
    n_start = 0;
    btn[0] = 1'b1;
    run(DEB + 2 + 350);
    btn[0] = 1'b0;
    run(120);
`ifdef OLED_AUTO_REPEAT_EN
    check("hold_requests", n_start, 4);
`else
    check("hold_requests", n_start, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
